// File: rtl/display_pkg.sv
// Shared seven-segment display constants and helpers.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package display_pkg;

   localparam logic [6:0] SEG_0    = 7'h40;
   localparam logic [6:0] SEG_1    = 7'h79;
   localparam logic [6:0] SEG_2    = 7'h24;
   localparam logic [6:0] SEG_3    = 7'h30;
   localparam logic [6:0] SEG_4    = 7'h19;
   localparam logic [6:0] SEG_5    = 7'h12;
   localparam logic [6:0] SEG_6    = 7'h02;
   localparam logic [6:0] SEG_7    = 7'h78;
   localparam logic [6:0] SEG_8    = 7'h00;
   localparam logic [6:0] SEG_9    = 7'h10;
   localparam logic [6:0] SEG_DASH = 7'h3F;   // only g lit

   localparam logic [3:0] AN_OFF   = 4'b1111;
   localparam logic [7:0] SSEG_OFF = 8'hFF;

   // Ceiling log2, never less than 1 so a counter always has a bit.
   function automatic int clog2(input int n);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++)
         if ((1 << i) < n) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/bcd_to_sseg.sv
// Combinational BCD digit to seven-segment decoder, active-low.
//   digit : 4-bit value; 0..9 decode normally, 10..15 show a dash
//   seg   : {g,f,e,d,c,b,a}, 0 = segment lit
module bcd_to_sseg
   import display_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      case (digit)
         4'd0: seg = SEG_0;
         4'd1: seg = SEG_1;
         4'd2: seg = SEG_2;
         4'd3: seg = SEG_3;
         4'd4: seg = SEG_4;
         4'd5: seg = SEG_5;
         4'd6: seg = SEG_6;
         4'd7: seg = SEG_7;
         4'd8: seg = SEG_8;
         4'd9: seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/bcd4_scan_display.sv
// Time-multiplexed driver for a common-anode 4-digit seven-segment display.
// Digits are snapshotted into a shadow register only at frame boundaries so a
// frame never mixes old and new values.
//   clk, rst_n     : clock, async active-low reset
//   d3..d0         : BCD digits (d3 most significant), sampled at frame ends
//   hold           : 1 = keep the current snapshot
//   lz_blank       : 1 = blank leading zeros (digit 0 always shown)
//   an             : anode enables, active-low
//   sseg           : {dp,g,f,e,d,c,b,a}, active-low
//   frame_done     : one-cycle pulse after each frame boundary
module bcd4_scan_display
   import display_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter int DP_POS      = 2
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] d3,
   input  logic [3:0] d2,
   input  logic [3:0] d1,
   input  logic [3:0] d0,
   input  logic       hold,
   input  logic       lz_blank,
   output logic [3:0] an,
   output logic [7:0] sseg,
   output logic       frame_done
);

   localparam int               CNT_W   = clog2(REFRESH_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

   logic [CNT_W-1:0] cnt;
   logic [1:0]       idx;
   logic [3:0][3:0]  shadow;     // shadow[3] is the most significant digit

   logic       slot_tick, frame_end;
   logic [3:0] cur_digit;
   logic [6:0] cur_seg;
   logic       blank, dp_on;

   assign slot_tick = (cnt == CNT_MAX);
   assign frame_end = slot_tick && (idx == 2'd3);
   assign cur_digit = shadow[idx];

   bcd_to_sseg u_dec (
      .digit (cur_digit),
      .seg   (cur_seg)
   );

   // Blanking looks only at the snapshot; invalid digits count as nonzero.
   always_comb begin
      blank = 1'b0;
      case (idx)
         2'd3: blank = lz_blank && (shadow[3] == 4'd0);
         2'd2: blank = lz_blank && (shadow[3] == 4'd0) && (shadow[2] == 4'd0);
         2'd1: blank = lz_blank && (shadow[3] == 4'd0) && (shadow[2] == 4'd0)
                                && (shadow[1] == 4'd0);
         default: blank = 1'b0;
      endcase
   end

   // DP_POS of 4 (or any value outside 0..3) never matches.
   assign dp_on = (int'(idx) == DP_POS);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         idx        <= 2'd0;
         shadow     <= '0;
         frame_done <= 1'b0;
         an         <= AN_OFF;
         sseg       <= SSEG_OFF;
      end else begin
         cnt <= slot_tick ? '0 : cnt + CNT_W'(1);
         if (slot_tick) idx <= idx + 2'd1;
         if (frame_end && !hold) shadow <= {d3, d2, d1, d0};
         frame_done <= frame_end;
         // Outputs follow the current index/snapshot one cycle later.
         if (blank) begin
            an   <= AN_OFF;
            sseg <= SSEG_OFF;
         end else begin
            an   <= ~(4'b0001 << idx);
            sseg <= {~dp_on, cur_seg};
         end
      end
   end

endmodule

// File: tb/tb_bcd4_scan_display.sv
module tb_bcd4_scan_display;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] d3 = 4'd0, d2 = 4'd0, d1 = 4'd0, d0 = 4'd0;
   logic       hold = 1'b0, lz_blank = 1'b0;
   logic [3:0] an;
   logic [7:0] sseg;
   logic       frame_done;

   int n_chk = 0;
   int n_pass = 0;
   logic [3:0] fr_an [4];
   logic [7:0] fr_ss [4];

   bcd4_scan_display #(.REFRESH_DIV(4), .DP_POS(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .d3         (d3),
      .d2         (d2),
      .d1         (d1),
      .d0         (d0),
      .hold       (hold),
      .lz_blank   (lz_blank),
      .an         (an),
      .sseg       (sseg),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   function automatic logic [6:0] seg7(input logic [3:0] v);
      case (v)
         4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
         4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
         4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
         4'd9: return 7'h10;
         default: return 7'h3F;
      endcase
   endfunction

   function automatic bit blanked(input int k, input logic [15:0] s, input bit lz);
      case (k)
         3: return lz && (s[15:12] == 4'd0);
         2: return lz && (s[15:8]  == 8'd0);
         1: return lz && (s[15:4]  == 12'd0);
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] exp_an(input int k, input logic [15:0] s, input bit lz);
      logic [3:0] one;
      one = 4'b0001;
      if (blanked(k, s, lz)) return 4'hF;
      return ~(one << k);
   endfunction

   function automatic logic [7:0] exp_ss(input int k, input logic [15:0] s, input bit lz);
      if (blanked(k, s, lz)) return 8'hFF;
      return {(k != 2), seg7(s[k*4 +: 4])};
   endfunction

   task automatic wait_fd();
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(posedge clk); #1;
         if (frame_done) begin seen = 1'b1; break; end
      end
      if (!seen) chk("fd_timeout", 32'd0, 32'd1);
   endtask

   // Call right after frame_done is seen: captures the four slots of the frame.
   task automatic get_frame();
      @(posedge clk); #1;
      fr_an[0] = an; fr_ss[0] = sseg;
      chk("fd_width", {31'd0, frame_done}, 32'd0);
      for (int k = 1; k < 4; k++) begin
         repeat (4) @(posedge clk);
         #1;
         fr_an[k] = an; fr_ss[k] = sseg;
      end
   endtask

   task automatic check_frame(input string tag, input logic [15:0] s, input bit lz);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("%s_an%0d", tag, k), {28'd0, fr_an[k]}, {28'd0, exp_an(k, s, lz)});
         chk($sformatf("%s_ss%0d", tag, k), {24'd0, fr_ss[k]}, {24'd0, exp_ss(k, s, lz)});
      end
   endtask

   task automatic set_d(input logic [15:0] v);
      {d3, d2, d1, d0} = v;
   endtask

   // Wiggle inputs every cycle except the one feeding the boundary edge,
   // where 'nxt' is presented. Verifies the frame shown equals 'cur'.
   task automatic scramble(input string tag, input logic [15:0] cur, input logic [15:0] nxt,
                           input bit do_chk);
      for (int e = 1; e <= 16; e++) begin
         @(posedge clk); #1;
         if (e == 1 || e == 5 || e == 9 || e == 13) begin
            fr_an[(e-1)/4] = an; fr_ss[(e-1)/4] = sseg;
         end
         if (e == 16) chk($sformatf("%s_fd", tag), {31'd0, frame_done}, 32'd1);
         if (e == 15) set_d(nxt);
         else set_d(16'($urandom));
      end
      if (do_chk) check_frame(tag, cur, 1'b0);
   endtask

   initial begin
      int lat;
      set_d(16'h1234);
      #12;
      chk("rst_an",   {28'd0, an},   32'hF);
      chk("rst_sseg", {24'd0, sseg}, 32'hFF);
      chk("rst_fd",   {31'd0, frame_done}, 32'd0);
      @(posedge clk); #2 rst_n = 1'b1;

      // first frame after reset shows the cleared snapshot
      lat = 0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         if (n == 2) begin
            chk("first_an",   {28'd0, an},   32'hE);
            chk("first_sseg", {24'd0, sseg}, 32'hC0);
         end
         if (frame_done) begin lat = n; break; end
      end
      chk("fd_latency", lat, 32'd16);
      get_frame();
      check_frame("f1234", 16'h1234, 1'b0);
      chk("f1234_dp_slot", {24'd0, fr_ss[2]}, 32'h24);

      // leading-zero blanking
      set_d(16'h0007); lz_blank = 1'b1;
      wait_fd(); get_frame();
      check_frame("lz7", 16'h0007, 1'b1);
      chk("lz7_d0", {24'd0, fr_ss[0]}, 32'hF8);
      lz_blank = 1'b0;
      wait_fd(); get_frame();
      check_frame("nolz7", 16'h0007, 1'b0);
      chk("nolz7_dp", {24'd0, fr_ss[2]}, 32'h40);

      // hold freezes the snapshot across frames
      set_d(16'h1234);
      wait_fd(); get_frame();
      set_d(16'h5678); hold = 1'b1;
      for (int f = 0; f < 3; f++) begin
         wait_fd(); get_frame();
         check_frame($sformatf("hold%0d", f), 16'h1234, 1'b0);
      end
      hold = 1'b0;
      @(posedge clk); #1;
      chk("hold_drop_an",   {28'd0, an},   32'h7);
      chk("hold_drop_sseg", {24'd0, sseg}, 32'hF9);
      wait_fd(); get_frame();
      check_frame("f5678", 16'h5678, 1'b0);
      chk("f5678_d2", {24'd0, fr_ss[2]}, 32'h02);

      // invalid digit shows a dash and counts as nonzero for blanking
      set_d(16'h0C12); lz_blank = 1'b1;
      wait_fd(); get_frame();
      check_frame("dash", 16'h0C12, 1'b1);
      chk("dash_d2", {24'd0, fr_ss[2]}, 32'h3F);
      chk("dash_an3", {28'd0, fr_an[3]}, 32'hF);

      // async reset mid-frame
      wait_fd();
      repeat (8) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_an",   {28'd0, an},   32'hF);
      chk("mid_rst_sseg", {24'd0, sseg}, 32'hFF);
      chk("mid_rst_fd",   {31'd0, frame_done}, 32'd0);
      repeat (2) @(posedge clk);
      #1 chk("rst_hold_an", {28'd0, an}, 32'hF);
      lz_blank = 1'b0;
      @(posedge clk); #2 rst_n = 1'b1;
      lat = 0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         if (n == 2) begin
            chk("rerst_an",   {28'd0, an},   32'hE);
            chk("rerst_sseg", {24'd0, sseg}, 32'hC0);
         end
         if (n == 6) chk("rerst_slot1", {28'd0, an}, 32'hD);
         if (frame_done) begin lat = n; break; end
      end
      chk("rerst_latency", lat, 32'd16);

      // inputs changing on every non-boundary cycle
      set_d(16'($urandom));
      scramble("scr0", 16'h0000, 16'h9805, 1'b0);
      scramble("scr1", 16'h9805, 16'h3069, 1'b1);
      scramble("scr2", 16'h3069, 16'h4271, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
